spi_frame_streamer: RTL

//  Parametrised successor of the single-channel SPI frame sender. On a start command it

---
 rtl/spi_frame_streamer.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_frame_streamer.sv
// SPI frame streamer: sends a big-endian length header, then streams pixel-reader
// bytes into an SPI slave core with abort, wr_ack timeout and byte counting.
module spi_frame_streamer #(
  parameter int ADDR_W    = 16,
  parameter int HDR_BYTES = 3,
  parameter int DATA_W    = 8,
  parameter int TMO_CYC   = 1024,
  parameter int CNT_W     = 24
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_stop_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  input  logic              i_rd_valid,
  input  logic              i_rd_done,
  output logic              o_rd_req,
  output logic              o_reader_reset,
  input  logic              i_di_req,
  input  logic              i_wr_ack,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_wren,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err_tmo,
  output logic [CNT_W-1:0]  o_bytes_sent
);

  localparam int HDR_W = HDR_BYTES * 8;
  localparam int IDX_W = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;
  localparam int TMO_W = $clog2(TMO_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_WAIT,
    S_HDR_WR,
    S_DAT_REQ,
    S_DAT_WAIT,
    S_DAT_WR,
    S_FINISH
  } state_t;

  state_t            r_state;
  logic [HDR_W-1:0]  r_hdr;
  logic [IDX_W-1:0]  r_hdr_idx;
  logic [DATA_W-1:0] r_data_out;
  logic              r_wren;
  logic              r_rd_req;
  logic              r_reader_reset;
  logic              r_done;
  logic              r_err_tmo;
  logic [CNT_W-1:0]  r_bytes_sent;
  logic              r_last;
  logic [TMO_W-1:0]  r_tmo_cnt;

  state_t            w_state_next;
  logic [HDR_W-1:0]  w_hdr_next;
  logic [IDX_W-1:0]  w_hdr_idx_next;
  logic [DATA_W-1:0] w_data_out_next;
  logic              w_wren_next;
  logic              w_rd_req_next;
  logic              w_reader_reset_next;
  logic              w_done_next;
  logic              w_err_tmo_next;
  logic [CNT_W-1:0]  w_bytes_sent_next;
  logic              w_last_next;
  logic [TMO_W-1:0]  w_tmo_cnt_next;

  logic [7:0]        w_hdr_byte;
  logic              w_tmo_hit;
  logic              w_hdr_last;

  // The header register shifts left after every acked header byte, so the
  // byte to send is always the top one.
  assign w_hdr_byte = r_hdr[HDR_W-1 -: 8];
  assign w_tmo_hit  = (r_tmo_cnt == TMO_W'(TMO_CYC - 1));
  assign w_hdr_last = (r_hdr_idx == IDX_W'(HDR_BYTES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_hdr          <= '0;
      r_hdr_idx      <= '0;
      r_data_out     <= '0;
      r_wren         <= 1'b0;
      r_rd_req       <= 1'b0;
      r_reader_reset <= 1'b0;
      r_done         <= 1'b0;
      r_err_tmo      <= 1'b0;
      r_bytes_sent   <= '0;
      r_last         <= 1'b0;
      r_tmo_cnt      <= '0;
    end else begin
      r_state        <= w_state_next;
      r_hdr          <= w_hdr_next;
      r_hdr_idx      <= w_hdr_idx_next;
      r_data_out     <= w_data_out_next;
      r_wren         <= w_wren_next;
      r_rd_req       <= w_rd_req_next;
      r_reader_reset <= w_reader_reset_next;
      r_done         <= w_done_next;
      r_err_tmo      <= w_err_tmo_next;
      r_bytes_sent   <= w_bytes_sent_next;
      r_last         <= w_last_next;
      r_tmo_cnt      <= w_tmo_cnt_next;
    end
  end

  always_comb begin
    w_state_next        = r_state;
    w_hdr_next          = r_hdr;
    w_hdr_idx_next      = r_hdr_idx;
    w_data_out_next     = r_data_out;
    w_wren_next         = r_wren;
    w_rd_req_next       = 1'b0;
    w_reader_reset_next = 1'b0;
    w_done_next         = 1'b0;
    w_err_tmo_next      = r_err_tmo;
    w_bytes_sent_next   = r_bytes_sent;
    w_last_next         = r_last;
    w_tmo_cnt_next      = r_tmo_cnt;

    if (i_abort) begin
      w_state_next        = S_IDLE;
      w_wren_next         = 1'b0;
      w_reader_reset_next = (r_state != S_IDLE);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            w_hdr_next          = HDR_W'(i_stop_addr);
            w_hdr_idx_next      = '0;
            w_bytes_sent_next   = '0;
            w_err_tmo_next      = 1'b0;
            w_reader_reset_next = 1'b1;
            w_state_next        = S_HDR_WAIT;
          end
        end

        S_HDR_WAIT: begin
          if (i_di_req) begin
            w_data_out_next = DATA_W'(w_hdr_byte);
            w_wren_next     = 1'b1;
            w_tmo_cnt_next  = '0;
            w_state_next    = S_HDR_WR;
          end
        end

        S_HDR_WR: begin
          if (i_wr_ack) begin
            w_wren_next = 1'b0;
            if (w_hdr_last) begin
              w_rd_req_next = 1'b1;
              w_state_next  = S_DAT_REQ;
            end else begin
              w_hdr_idx_next = r_hdr_idx + 1'b1;
              w_hdr_next     = r_hdr << 8;
              w_state_next   = S_HDR_WAIT;
            end
          end else if (w_tmo_hit) begin
            w_wren_next         = 1'b0;
            w_err_tmo_next      = 1'b1;
            w_reader_reset_next = 1'b1;
            w_state_next        = S_IDLE;
          end else begin
            w_tmo_cnt_next = r_tmo_cnt + 1'b1;
          end
        end

        S_DAT_REQ: begin
          w_state_next = S_DAT_WAIT;
        end

        // A byte already presented by the reader simply waits for the SPI
        // core; no further rd_req is issued until it has been consumed.
        S_DAT_WAIT: begin
          if (i_rd_valid && i_di_req) begin
            w_data_out_next = i_rd_data;
            w_wren_next     = 1'b1;
            w_last_next     = i_rd_done;
            w_tmo_cnt_next  = '0;
            w_state_next    = S_DAT_WR;
          end
        end

        S_DAT_WR: begin
          if (i_wr_ack) begin
            w_wren_next = 1'b0;
            if (r_bytes_sent != {CNT_W{1'b1}}) begin
              w_bytes_sent_next = r_bytes_sent + 1'b1;
            end
            if (r_last) begin
              w_done_next     = 1'b1;
              w_data_out_next = '0;
              w_state_next    = S_FINISH;
            end else begin
              w_rd_req_next = 1'b1;
              w_state_next  = S_DAT_REQ;
            end
          end else if (w_tmo_hit) begin
            w_wren_next         = 1'b0;
            w_err_tmo_next      = 1'b1;
            w_reader_reset_next = 1'b1;
            w_state_next        = S_IDLE;
          end else begin
            w_tmo_cnt_next = r_tmo_cnt + 1'b1;
          end
        end

        S_FINISH: begin
          w_state_next = S_IDLE;
        end

        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  assign o_rd_req       = r_rd_req;
  assign o_reader_reset = r_reader_reset;
  assign o_data_out     = r_data_out;
  assign o_wren         = r_wren;
  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = r_done;
  assign o_err_tmo      = r_err_tmo;
  assign o_bytes_sent   = r_bytes_sent;

endmodule
